// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the ALU clients and the shared ALU arbiter.
// The master side drives requests and response acceptance.
// The slave side is the arbiter itself.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int RID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [4*NUM_REQ-1:0]      req_opcode;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [RID_W-1:0]          rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic [15:0]               op_count;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, op_count
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shared 8-bit ALU arbiter: round-robin grant among NUM_REQ clients, operand
// capture, one registered execute cycle and a held response with zero flag.
// Optional feature macro: ALU_ARB_PERF_CNT_EN builds a saturating completed-op
// counter on op_count; without it op_count is tied to zero.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus
);
    localparam int RID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [RID_W-1:0]    r_rrPtr;
    logic [RID_W-1:0]    r_grantId;
    logic [3:0]          r_opcode;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [RID_W-1:0]    r_rspId;
    logic [DATA_W-1:0]   r_rspResult;
    logic                r_rspZero;

    logic                w_anyValid;
    logic [RID_W-1:0]    w_grantId;
    logic [RID_W-1:0]    w_scanIdx;
    logic [NUM_REQ-1:0]  w_reqReady;
    logic                w_grantFire;
    logic                w_rspAccept;
    logic [DATA_W-1:0]   w_bcdSum;
    logic [DATA_W-1:0]   w_aluResult;
    logic [RID_W-1:0]    w_nextPtr;
    logic [DATA_W-1:0]   w_sel;

    // Round-robin scan: the lowest offset from r_rrPtr with valid set wins.
    always_comb begin
        w_anyValid = |bus.req_valid;
        w_grantId  = '0;
        w_scanIdx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scanIdx = RID_W'((int'(r_rrPtr) + k) % NUM_REQ);
            if (bus.req_valid[w_scanIdx]) begin
                w_grantId = w_scanIdx;
            end
        end
    end

    // Next-state logic and the combinational one-hot grant strobe.
    always_comb begin
        w_nextState = r_state;
        w_reqReady  = '0;
        w_grantFire = 1'b0;
        w_rspAccept = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyValid && !rst) begin
                    w_reqReady[w_grantId] = 1'b1;
                    w_grantFire           = 1'b1;
                    w_nextState           = EXEC;
                end
            end
            EXEC: begin
                w_nextState = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rspAccept = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ALU on the captured operands; undefined opcodes produce zero.
    always_comb begin
        w_bcdSum    = r_a + r_b;
        w_sel       = '0;
        w_aluResult = '0;
        case (r_opcode)
            4'd0: w_aluResult = r_a + r_b;
            4'd1: w_aluResult = r_a - r_b;
            4'd2: w_aluResult = r_a & r_b;
            4'd3: w_aluResult = r_a | r_b;
            4'd4: w_aluResult = r_a ^ r_b;
            4'd5: w_aluResult = ~r_a;
            4'd6: begin
                w_sel       = (w_bcdSum > DATA_W'(9)) ? DATA_W'(6) : '0;
                w_aluResult = w_bcdSum + w_sel;
            end
            default: w_aluResult = '0;
        endcase
    end

    assign w_nextPtr = (int'(r_grantId) == NUM_REQ - 1) ? '0 : r_grantId + RID_W'(1);

    // State register; reset drops any pending operation back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand capture, registered execute result and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr     <= '0;
            r_grantId   <= '0;
            r_opcode    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rspId     <= '0;
            r_rspResult <= '0;
            r_rspZero   <= 1'b0;
        end else begin
            if (w_grantFire) begin
                r_grantId <= w_grantId;
                r_opcode  <= bus.req_opcode[4*w_grantId +: 4];
                r_a       <= bus.req_a[DATA_W*w_grantId +: DATA_W];
                r_b       <= bus.req_b[DATA_W*w_grantId +: DATA_W];
            end
            if (r_state == EXEC) begin
                r_rspId     <= r_grantId;
                r_rspResult <= w_aluResult;
                r_rspZero   <= (w_aluResult == '0);
            end
            if (w_rspAccept) begin
                r_rrPtr <= w_nextPtr;
            end
        end
    end

    assign bus.req_ready  = w_reqReady;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_rspId;
    assign bus.rsp_result = r_rspResult;
    assign bus.rsp_zero   = r_rspZero;

`ifdef ALU_ARB_PERF_CNT_EN
    logic [15:0] r_opCount;

    // Saturating count of accepted responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opCount <= 16'h0000;
        end else if (w_rspAccept && (r_opCount != 16'hFFFF)) begin
            r_opCount <= r_opCount + 16'h0001;
        end
    end

    assign bus.op_count = r_opCount;
`else
    assign bus.op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter (NUM_REQ=4, DATA_W=8).
module tb_alu_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    typedef struct {
        logic [1:0] id;
        logic [7:0] result;
        logic       zero;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   expOpCount = 0;
    int   lastGrant = 0;
    expT  sb[$];

    logic [3:0] opTab[4];
    logic [7:0] aTab[4];
    logic [7:0] bTab[4];

    alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and cycle counter used for spacing checks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [7:0] aluModel(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        case (opc)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: begin
                s = a + b;
                return (s > 8'd9) ? s + 8'd6 : s;
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] expCount();
`ifdef ALU_ARB_PERF_CNT_EN
        return 16'(expOpCount);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpected(input int id);
        expT e;
        e.id     = id[1:0];
        e.result = aluModel(opTab[id], aTab[id], bTab[id]);
        e.zero   = (e.result == 8'h00);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int id, input logic [3:0] opc, input logic [7:0] a,
                                 input logic [7:0] b, input bit push);
        opTab[id] = opc;
        aTab[id]  = a;
        bTab[id]  = b;
        bus.req_opcode[4*id +: 4] = opc;
        bus.req_a[8*id +: 8]      = a;
        bus.req_b[8*id +: 8]      = b;
        bus.req_valid[id[1:0]]    = 1'b1;
        if (push) pushExpected(id);
    endtask

    task automatic waitGrant(input int expId);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready == '0 && n < 20);
        checkVal("grant", 32'(bus.req_ready), 32'(1 << expId));
    endtask

    task automatic checkOutput(input int maxWait);
        expT e;
        int  n = 1;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && n < maxWait) begin
            @(negedge clk);
            n++;
        end
        checkVal("rspValid", 32'(bus.rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            checkVal("rspId", 32'(bus.rsp_id), 32'(e.id));
            checkVal("rspResult", 32'(bus.rsp_result), 32'(e.result));
            checkVal("rspZero", 32'(bus.rsp_zero), 32'(e.zero));
        end
        checkVal("opCount", 32'(bus.op_count), 32'(expCount()));
        if (bus.rsp_ready === 1'b1) expOpCount++;
    endtask

    task automatic runOp(input int id, input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
        applyStimulus(id, opc, a, b, 1'b1);
        waitGrant(id);
        @(posedge clk);
        #1;
        bus.req_valid[id[1:0]] = 1'b0;
        @(negedge clk);
        checkVal("execNoRsp", 32'(bus.rsp_valid), 32'd0);
        checkOutput(1);
        @(posedge clk);
        #1;
    endtask

    // Linear directed sequence.
    initial begin
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state, including no grant while reset is held with a request pending.
        bus.req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rstReady", 32'(bus.req_ready), 32'd0);
        checkVal("rstRspValid", 32'(bus.rsp_valid), 32'd0);
        checkVal("rstRspId", 32'(bus.rsp_id), 32'd0);
        checkVal("rstResult", 32'(bus.rsp_result), 32'd0);
        checkVal("rstZero", 32'(bus.rsp_zero), 32'd0);
        checkVal("rstOpCount", 32'(bus.op_count), 32'd0);
        bus.req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-requester operations; the last one is from requester 3 so rr_ptr returns to 0.
        runOp(0, 4'd0, 8'h05, 8'h03);
        runOp(1, 4'd6, 8'h07, 8'h05);
        runOp(2, 4'd6, 8'h04, 8'h05);
        runOp(3, 4'd1, 8'h03, 8'h05);
        runOp(0, 4'h9, 8'hFF, 8'h00);
        runOp(1, 4'd5, 8'hFF, 8'h00);
        runOp(2, 4'd3, 8'h81, 8'h42);
        runOp(0, 4'd0, 8'hFF, 8'h01);
        runOp(1, 4'd2, 8'hF0, 8'h3C);
        runOp(3, 4'd4, 8'h0F, 8'hFF);

        // All four requesters held valid: grants 0,1,2,3,0 every third cycle.
        applyStimulus(0, 4'd0, 8'h10, 8'h20, 1'b0);
        applyStimulus(1, 4'd1, 8'h10, 8'h20, 1'b0);
        applyStimulus(2, 4'd6, 8'h09, 8'h01, 1'b0);
        applyStimulus(3, 4'hF, 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 5; i++) begin
            waitGrant(i % 4);
            if (i > 0) checkVal("grantSpacing", 32'(cycleCnt - lastGrant), 32'd3);
            lastGrant = cycleCnt;
            pushExpected(i % 4);
            @(posedge clk);
            #1;
            checkOutput(2);
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;

        // Backpressure on requester 2 while requester 1 waits.
        bus.rsp_ready = 1'b0;
        applyStimulus(2, 4'd2, 8'hF0, 8'h3C, 1'b1);
        waitGrant(2);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1, 4'd3, 8'h81, 8'h42, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkVal("bpValid", 32'(bus.rsp_valid), 32'd1);
            checkVal("bpReady", 32'(bus.req_ready), 32'd0);
            checkVal("bpResult", 32'(bus.rsp_result), 32'h30);
            checkVal("bpId", 32'(bus.rsp_id), 32'd2);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        checkOutput(1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("idleRspValid", 32'(bus.rsp_valid), 32'd0);
        checkVal("idleGrant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        checkOutput(2);
        @(posedge clk);
        #1;

        // Reset while a response is held: it is discarded and rr_ptr returns to 0.
        bus.rsp_ready = 1'b0;
        applyStimulus(2, 4'd0, 8'h01, 8'h01, 1'b0);
        waitGrant(2);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkVal("preRstValid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expOpCount = 0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkVal("postRstValid", 32'(bus.rsp_valid), 32'd0);
        checkVal("postRstResult", 32'(bus.rsp_result), 32'd0);
        checkVal("postRstOpCount", 32'(bus.op_count), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1, 4'd4, 8'h55, 8'hAA, 1'b1);
        applyStimulus(3, 4'd1, 8'h00, 8'h01, 1'b0);
        waitGrant(1);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        checkOutput(2);
        @(posedge clk);
        #1;
        waitGrant(3);
        pushExpected(3);
        @(posedge clk);
        #1;
        bus.req_valid[3] = 1'b0;
        checkOutput(2);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("finalOpCount", 32'(bus.op_count), 32'(expCount()));
        checkVal("sbDrained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
